// File: rtl/sram_bank_ctrl.sv
// Clocked initiator for a bank of DataWidth asynchronous 4096x1 SRAM chips wired in parallel.
// Turns a valid/ready request into CS_n/WE_n/OE_n strobe sequences with programmable cycle counts.
module sram_bank_ctrl #(
   parameter int DataWidth   = 64,
   parameter int AddressSize = 12,
   parameter int SetupCyc    = 1,
   parameter int WeCyc       = 2,
   parameter int RdCyc       = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [AddressSize-1:0] req_addr,
   input  logic [DataWidth-1:0]   req_wdata,
   output logic                   rd_valid,
   output logic [DataWidth-1:0]   rd_data,
   output logic                   wr_done,
   output logic [AddressSize-1:0] mem_addr,
   output logic [DataWidth-1:0]   mem_din,
   input  logic [DataWidth-1:0]   mem_dout,
   output logic                   mem_cs_n,
   output logic                   mem_we_n,
   output logic                   mem_oe_n
);

   // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_write, req_addr and req_wdata are captured on that edge and may change afterwards.

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WPULSE,
      WHOLD,
      RACCESS,
      RECOVER
   } state_t;

   // Counters hold N-1 so a cycle count of 1 gives a single-cycle state.
   localparam logic [3:0] SetupLd = 4'(SetupCyc - 1);
   localparam logic [3:0] WeLd    = 4'(WeCyc - 1);
   localparam logic [3:0] RdLd    = 4'(RdCyc - 1);

   state_t     state;
   logic [3:0] cnt;

   assign req_ready = (state == IDLE) && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         mem_cs_n <= 1'b1;
         mem_we_n <= 1'b1;
         mem_oe_n <= 1'b1;
         mem_addr <= '0;
         mem_din  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         wr_done  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         wr_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr <= req_addr;
                  mem_cs_n <= 1'b0;
                  if (req_write) begin
                     mem_din <= req_wdata;
                     state   <= SETUP;
                     cnt     <= SetupLd;
                  end else begin
                     mem_oe_n <= 1'b0;
                     state    <= RACCESS;
                     cnt      <= RdLd;
                  end
               end
            end
            SETUP: begin
               if (cnt == 4'd0) begin
                  mem_we_n <= 1'b0;
                  state    <= WPULSE;
                  cnt      <= WeLd;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WPULSE: begin
               if (cnt == 4'd0) begin
                  mem_we_n <= 1'b1;
                  wr_done  <= 1'b1;
                  state    <= WHOLD;
                  cnt      <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WHOLD: begin
               // Address and data stay put one cycle past the WE_n rising edge.
               mem_cs_n <= 1'b1;
               state    <= RECOVER;
               cnt      <= 4'd0;
            end
            RACCESS: begin
               if (cnt == 4'd0) begin
                  rd_data  <= mem_dout;
                  rd_valid <= 1'b1;
                  mem_cs_n <= 1'b1;
                  mem_oe_n <= 1'b1;
                  state    <= RECOVER;
                  cnt      <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RECOVER: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
            default: begin
               mem_cs_n <= 1'b1;
               mem_we_n <= 1'b1;
               mem_oe_n <= 1'b1;
               state    <= IDLE;
               cnt      <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: two instances (default timing and 3/1/5 timing), each with a chip bank model.
// Driver issues directed requests; a monitor checks the strobe timeline per cycle and pops read data.
module tb_sram_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst_n      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [11:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic        rd_valid   [2];
   logic [63:0] rd_data    [2];
   logic        wr_done    [2];
   logic [11:0] mem_addr   [2];
   logic [63:0] mem_din    [2];
   logic [63:0] mem_dout   [2];
   logic        mem_cs_n   [2];
   logic        mem_we_n   [2];
   logic        mem_oe_n   [2];

   logic [63:0] bank0 [4096];
   logic [63:0] bank1 [4096];

   logic [63:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   // ---------------- DUTs ----------------
   sram_bank_ctrl dut_a (
      .clk(clk), .rst_n(rst_n[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .wr_done(wr_done[0]),
      .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]),
      .mem_cs_n(mem_cs_n[0]), .mem_we_n(mem_we_n[0]), .mem_oe_n(mem_oe_n[0])
   );

   sram_bank_ctrl #(.SetupCyc(3), .WeCyc(1), .RdCyc(5)) dut_b (
      .clk(clk), .rst_n(rst_n[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .wr_done(wr_done[1]),
      .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]),
      .mem_cs_n(mem_cs_n[1]), .mem_we_n(mem_we_n[1]), .mem_oe_n(mem_oe_n[1])
   );

   // ---------------- chip bank models ----------------
   assign mem_dout[0] = (!mem_cs_n[0] && !mem_oe_n[0]) ? bank0[mem_addr[0]] : 'x;
   assign mem_dout[1] = (!mem_cs_n[1] && !mem_oe_n[1]) ? bank1[mem_addr[1]] : 'x;

   always @(negedge clk) begin
      if (!mem_cs_n[0] && !mem_we_n[0]) bank0[mem_addr[0]] <= mem_din[0];
      if (!mem_cs_n[1] && !mem_we_n[1]) bank1[mem_addr[1]] <= mem_din[1];
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %h, expected %h", name, i, got, exp);
      end
   endtask

   function automatic int p_setup(input int i); return (i == 0) ? 1 : 3; endfunction
   function automatic int p_we(input int i);    return (i == 0) ? 2 : 1; endfunction
   function automatic int p_rd(input int i);    return (i == 0) ? 3 : 5; endfunction

   // ---------------- driver ----------------
   // Caller is at a negedge. Returns at the negedge after the accepting edge.
   task automatic issue(input int i, input bit wr, input logic [11:0] a, input logic [63:0] d, input bit hold);
      int budget;
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_addr[i]  = a;
      req_wdata[i] = d;
      if (!wr) exp_q.push_back(d);
      budget = 0;
      #1;
      while (!req_ready[i] && budget < 100) begin
         @(negedge clk);
         #1;
         budget++;
      end
      chk("accept_within_budget", i, 64'(budget < 100), 64'd1);
      @(negedge clk);
      if (!hold) req_valid[i] = 1'b0;
   endtask

   // ---------------- monitor ----------------
   bit          act      [2] = '{0, 0};
   bit          pend     [2] = '{0, 0};
   bit          pend_wr  [2];
   bit          wr_t     [2];
   int          k        [2];
   logic [11:0] p_addr   [2];
   logic [11:0] t_addr   [2];
   logic [63:0] p_data   [2];
   logic [63:0] last_din [2] = '{64'd0, 64'd0};
   logic        rst_prev [2] = '{1'b0, 1'b0};
   logic        prev_cs  [2] = '{1'b1, 1'b1};
   logic [11:0] prev_addr[2];
   logic [63:0] prev_din [2];

   task automatic mon_step(input int i);
      int s, w, r, last;
      logic [5:0] got_v, exp_v;
      logic ecs, ewe, eoe, erv, ewd, erdy;
      s = p_setup(i);
      w = p_we(i);
      r = p_rd(i);
      got_v = {mem_cs_n[i], mem_we_n[i], mem_oe_n[i], rd_valid[i], wr_done[i], req_ready[i]};
      if (!rst_prev[i]) begin
         act[i]      = 0;
         pend[i]     = 0;
         last_din[i] = 64'd0;
         chk("reset_strobes", i, 64'(got_v), 64'({3'b111, 2'b00, rst_n[i]}));
         chk("reset_addr_din_rd_zero", i,
             64'(mem_addr[i] == 12'd0 && mem_din[i] == 64'd0 && rd_data[i] == 64'd0), 64'd1);
      end else begin
         if (pend[i]) begin
            act[i]  = 1;
            k[i]    = 1;
            wr_t[i] = pend_wr[i];
            t_addr[i] = p_addr[i];
            if (pend_wr[i]) last_din[i] = p_data[i];
            pend[i] = 0;
         end else if (act[i]) begin
            k[i]++;
         end
         ecs = 1; ewe = 1; eoe = 1; erv = 0; ewd = 0; erdy = 1;
         last = 0;
         if (act[i]) begin
            if (wr_t[i]) begin
               last = s + w + 3;
               ecs  = !(k[i] <= s + w + 1);
               ewe  = !(k[i] >= s + 1 && k[i] <= s + w);
               ewd  = (k[i] == s + w + 1);
            end else begin
               last = r + 2;
               ecs  = !(k[i] <= r);
               eoe  = !(k[i] <= r);
               erv  = (k[i] == r + 1);
            end
            erdy = (k[i] == last);
         end
         exp_v = {ecs, ewe, eoe, erv, ewd, erdy};
         chk("strobes", i, 64'(got_v), 64'(exp_v));
         if (act[i] && !ecs) chk("mem_addr", i, 64'(mem_addr[i]), 64'(t_addr[i]));
         chk("mem_din", i, mem_din[i], last_din[i]);
         if (rd_valid[i]) begin
            if (exp_q.size() == 0) chk("rd_unexpected", i, 64'd1, 64'd0);
            else chk("rd_data", i, rd_data[i], exp_q.pop_front());
         end
         if (act[i] && k[i] == last) act[i] = 0;
      end
      chk("we_oe_exclusive", i, 64'(mem_we_n[i] | mem_oe_n[i]), 64'd1);
      if (!prev_cs[i] && !mem_cs_n[i])
         chk("addr_din_stable", i,
             64'({mem_addr[i] == prev_addr[i], mem_din[i] == prev_din[i]}), 64'b11);
      prev_cs[i]   = mem_cs_n[i];
      prev_addr[i] = mem_addr[i];
      prev_din[i]  = mem_din[i];
      if (rst_n[i] && req_valid[i] && req_ready[i]) begin
         pend[i]    = 1;
         pend_wr[i] = req_write[i];
         p_addr[i]  = req_addr[i];
         p_data[i]  = req_wdata[i];
      end
      rst_prev[i] = rst_n[i];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < 2; i++) mon_step(i);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i]     = 1'b0;
         req_valid[i] = 1'b1;
         req_write[i] = 1'b1;
         req_addr[i]  = 12'h3C3;
         req_wdata[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         rst_n[i]     = 1'b1;
         req_valid[i] = 1'b0;
      end
      @(negedge clk);

      // default timing: single write then read back
      issue(0, 1, 12'h7FF, 64'hA5A5_0000_FFFF_1234, 0);
      issue(0, 0, 12'h7FF, 64'hA5A5_0000_FFFF_1234, 0);

      // alternating accesses at the address extremes with req_valid held high
      issue(0, 1, 12'h000, 64'h0123_4567_89AB_CDEF, 1);
      issue(0, 0, 12'h000, 64'h0123_4567_89AB_CDEF, 1);
      issue(0, 1, 12'hFFF, 64'hFEDC_BA98_7654_3210, 1);
      issue(0, 0, 12'hFFF, 64'hFEDC_BA98_7654_3210, 1);
      issue(0, 1, 12'h000, 64'h5555_AAAA_0F0F_F0F0, 1);
      issue(0, 0, 12'h000, 64'h5555_AAAA_0F0F_F0F0, 1);
      issue(0, 0, 12'hFFF, 64'hFEDC_BA98_7654_3210, 0);

      // reset while WE_n is low, then read an unrelated address
      issue(0, 1, 12'h123, 64'hDEAD_BEEF_CAFE_F00D, 0);
      @(negedge clk);
      rst_n[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      issue(0, 0, 12'h7FF, 64'hA5A5_0000_FFFF_1234, 0);

      // stretched timing instance
      issue(1, 1, 12'h055, 64'h1111_2222_3333_4444, 0);
      issue(1, 0, 12'h055, 64'h1111_2222_3333_4444, 0);
      issue(1, 1, 12'hABC, 64'h8000_0000_0000_0001, 1);
      issue(1, 0, 12'hABC, 64'h8000_0000_0000_0001, 1);
      issue(1, 0, 12'h055, 64'h1111_2222_3333_4444, 0);

      repeat (12) @(negedge clk);
      chk("exp_q_drained", 0, 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
